// File: rtl/lsq_mem_sched_pkg.sv
// Shared parameters, state encoding and request payload for the LSQ D-cache port scheduler.
package lsq_mem_sched_pkg;

  localparam int unsigned PIPE_WIDTH   = 2;
  localparam int unsigned TAG_WIDTH    = 6;
  localparam int unsigned CREDIT_MAX   = 8;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CREDIT_W     = $clog2(CREDIT_MAX + 1);
  localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_WAIT, MS_KILL} memsched_state_t;

  // Operation currently owning the D-cache port
  typedef struct packed {
    logic                 is_store;
    logic [TAG_WIDTH-1:0] tag;
  } mem_op_t;

endpackage

// File: rtl/lsq_mem_sched_if.sv
// Bundle of LSQ, ROB-commit and D-cache port signals around the memory scheduler.
interface lsq_mem_sched_if;
  import lsq_mem_sched_pkg::*;

  logic                  flush;
  logic [PIPE_WIDTH-1:0] commit_store_vals;
  logic                  st_req_valid;
  logic [TAG_WIDTH-1:0]  st_req_tag;
  logic                  st_pop;
  logic                  ld_req_valid;
  logic [TAG_WIDTH-1:0]  ld_req_tag;
  logic                  ld_pop;
  logic                  mem_req_valid;
  logic                  mem_req_is_store;
  logic [TAG_WIDTH-1:0]  mem_req_tag;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic                  ld_done_valid;
  logic [TAG_WIDTH-1:0]  ld_done_tag;
  logic [CREDIT_W-1:0]   credit_cnt;
  logic                  busy;

  // Scheduler side
  modport slave (
    input  flush, commit_store_vals, st_req_valid, st_req_tag, ld_req_valid, ld_req_tag,
           mem_req_ready, mem_resp_valid,
    output st_pop, ld_pop, mem_req_valid, mem_req_is_store, mem_req_tag,
           ld_done_valid, ld_done_tag, credit_cnt, busy
  );

  // LSQ / ROB / D-cache side
  modport master (
    output flush, commit_store_vals, st_req_valid, st_req_tag, ld_req_valid, ld_req_tag,
           mem_req_ready, mem_resp_valid,
    input  st_pop, ld_pop, mem_req_valid, mem_req_is_store, mem_req_tag,
           ld_done_valid, ld_done_tag, credit_cnt, busy
  );

endinterface

// File: rtl/lsq_mem_sched.sv
// Single D-cache port scheduler: store-head vs oldest-ready-load arbitration, one op in flight,
// committed-store credit tracking and load-over-store starvation ageing.
module lsq_mem_sched
  import lsq_mem_sched_pkg::*;
(
  input logic            clk,
  input logic            rst,
  lsq_mem_sched_if.slave sched_if
);

  localparam logic [1:0] ST_IDLE = 2'(MS_IDLE);
  localparam logic [1:0] ST_REQ  = 2'(MS_REQ);
  localparam logic [1:0] ST_WAIT = 2'(MS_WAIT);
  localparam logic [1:0] ST_KILL = 2'(MS_KILL);

  function automatic logic [CREDIT_W-1:0] popcount(input logic [PIPE_WIDTH-1:0] v);
    logic [CREDIT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) n = n + CREDIT_W'(v[i]);
    return n;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  mem_op_t             op_q, op_d;
  logic                req_valid_q, req_valid_d;
  logic                st_elig_c, ld_elig_c;
  logic                st_grant_c, ld_grant_c, ld_done_c;
  logic [CREDIT_W:0]   credit_sum_c;

  // Arbitration, port FSM, starvation and credit next-state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    req_valid_d = req_valid_q;
    starve_d    = starve_q;
    st_grant_c  = 1'b0;
    ld_grant_c  = 1'b0;
    ld_done_c   = 1'b0;
    st_elig_c   = sched_if.st_req_valid && (credit_q != '0);
    ld_elig_c   = sched_if.ld_req_valid && !sched_if.flush;

    case (state_q)
      ST_IDLE: begin
        if (!sched_if.flush) begin
          if (st_elig_c && ((starve_q == STARVE_W'(STARVE_LIMIT)) ||
                            (credit_q >= CREDIT_W'(CREDIT_MAX - 1)) || !ld_elig_c))
            st_grant_c = 1'b1;
          else if (ld_elig_c)
            ld_grant_c = 1'b1;
        end
        if (st_grant_c || ld_grant_c) begin
          op_d.is_store = st_grant_c;
          op_d.tag      = st_grant_c ? sched_if.st_req_tag : sched_if.ld_req_tag;
          req_valid_d   = 1'b1;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        // A flushed load is withdrawn unless the cache takes it this very cycle
        if (!op_q.is_store && sched_if.flush) begin
          req_valid_d = 1'b0;
          state_d     = sched_if.mem_req_ready ? ST_KILL : ST_IDLE;
        end else if (sched_if.mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sched_if.mem_resp_valid) begin
          ld_done_c = !op_q.is_store && !sched_if.flush;
          state_d   = ST_IDLE;
        end else if (sched_if.flush && !op_q.is_store) begin
          state_d = ST_KILL;
        end
      end
      ST_KILL: begin
        if (sched_if.mem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!st_elig_c || st_grant_c)
      starve_d = '0;
    else if (ld_grant_c && (starve_q != STARVE_W'(STARVE_LIMIT)))
      starve_d = starve_q + STARVE_W'(1);

    credit_sum_c = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(popcount(sched_if.commit_store_vals))
                 - (CREDIT_W+1)'(st_grant_c);
    credit_d     = credit_sum_c[CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      starve_q    <= '0;
      op_q        <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      starve_q    <= starve_d;
      op_q        <= op_d;
      req_valid_q <= req_valid_d;
      assert (credit_sum_c <= (CREDIT_W+1)'(CREDIT_MAX));
      if (sched_if.mem_resp_valid) assert ((state_q == ST_WAIT) || (state_q == ST_KILL));
    end
  end

  assign sched_if.st_pop           = st_grant_c && !rst;
  assign sched_if.ld_pop           = ld_grant_c && !rst;
  assign sched_if.mem_req_valid    = req_valid_q;
  assign sched_if.mem_req_is_store = op_q.is_store;
  assign sched_if.mem_req_tag      = op_q.tag;
  assign sched_if.ld_done_valid    = ld_done_c && !rst;
  assign sched_if.ld_done_tag      = (ld_done_c && !rst) ? op_q.tag : '0;
  assign sched_if.credit_cnt       = credit_q;
  assign sched_if.busy             = (state_q != ST_IDLE);

endmodule
